// File: rtl/bs_cell_if.sv
// Operand/result bundle for the bs_cell bit-slice adder.
// The master drives operands and carry-in; the slave returns sum, carries and group terms.
interface bs_cell_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c;
    logic [WIDTH-1:0] s;
    logic             g;
    logic             p;
    logic             co;
    logic [WIDTH-1:0] s_q;
    logic             co_q;

    modport master (
        output x, y, c,
        input  s, g, p, co, s_q, co_q
    );

    modport slave (
        input  x, y, c,
        output s, g, p, co, s_q, co_q
    );
endinterface

// File: rtl/bs_cell.sv
// Bit-slice adder cell: combinational sum/carry/group generate-propagate plus a registered sum/carry copy.
// Define BS_CELL_RIPPLE_EN for serial ripple carries (min area); default is flattened lookahead (min depth).
module bs_cell #(
    parameter int unsigned WIDTH = 1
) (
    input  logic      clk,
    input  logic      rst,
    bs_cell_if.slave  bus
);
    localparam int unsigned W = WIDTH;

    logic [W:0]   k;
    logic [W-1:0] gi;
    logic [W-1:0] pi;
    logic         gg;
    logic         pp;
    logic         term;

    // Propagate is inclusive-OR, so sum still needs the explicit XOR of x and y.
    always_comb begin
        gi   = bus.x & bus.y;
        pi   = bus.x | bus.y;
        k    = '0;
        gg   = 1'b0;
        pp   = 1'b1;
        term = 1'b0;
`ifdef BS_CELL_RIPPLE_EN
        k[0] = bus.c;
        for (int unsigned i = 0; i < W; i++) begin
            k[i+1] = gi[i] | (pi[i] & k[i]);
            gg     = gi[i] | (pi[i] & gg);
            pp     = pp & pi[i];
        end
`else
        k[0] = bus.c;
        for (int unsigned i = 1; i <= W; i++) begin
            // Carry-in path through every lower propagate, then each generate through the propagates above it.
            term = bus.c;
            for (int unsigned m = 0; m < i; m++) begin
                term = term & pi[m];
            end
            k[i] = term;
            for (int unsigned j = 0; j < i; j++) begin
                term = gi[j];
                for (int unsigned m = j + 1; m < i; m++) begin
                    term = term & pi[m];
                end
                k[i] = k[i] | term;
            end
        end
        for (int unsigned j = 0; j < W; j++) begin
            term = gi[j];
            for (int unsigned m = j + 1; m < W; m++) begin
                term = term & pi[m];
            end
            gg = gg | term;
        end
        pp = &pi;
`endif
    end

    assign bus.s  = bus.x ^ bus.y ^ k[W-1:0];
    assign bus.co = k[W];
    assign bus.g  = gg;
    assign bus.p  = pp;

    // Pipeline copy; reset takes priority over the incoming data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.s_q  <= '0;
            bus.co_q <= 1'b0;
        end else begin
            bus.s_q  <= bus.s;
            bus.co_q <= bus.co;
        end
    end
endmodule

// File: tb/tb_bs_cell.sv
// Self-checking bench for bs_cell: WIDTH=1 exhaustive, WIDTH=4 vectors and registered path, WIDTH=8 random.
module tb_bs_cell;
    logic clk;
    logic rst;
    logic clk_nc;
    logic rst_nc;

    int tests;
    int fails;

    bs_cell_if #(.WIDTH(1)) if1  ();
    bs_cell_if #(.WIDTH(1)) ifnc ();
    bs_cell_if #(.WIDTH(4)) if4  ();
    bs_cell_if #(.WIDTH(8)) if8  ();

    bs_cell #(.WIDTH(1)) u_w1 (.clk(clk),    .rst(rst),    .bus(if1));
    bs_cell #(.WIDTH(1)) u_nc (.clk(clk_nc), .rst(rst_nc), .bus(ifnc));
    bs_cell #(.WIDTH(4)) u_w4 (.clk(clk),    .rst(rst),    .bus(if4));
    bs_cell #(.WIDTH(8)) u_w8 (.clk(clk),    .rst(rst),    .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       c;
        logic [3:0] s;
        logic       co;
        logic       g;
        logic       p;
    } vec4_t;

    vec4_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic       ex, ey, ec;
        logic [7:0] rx, ry;
        logic       rc;
        logic [8:0] full;
        logic [8:0] gen;
        logic       ep;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        clk_nc = 1'bx;
        rst_nc = 1'bx;
        if1.x = '0; if1.y = '0; if1.c = 1'b0;
        ifnc.x = '0; ifnc.y = '0; ifnc.c = 1'b0;
        if4.x = '0; if4.y = '0; if4.c = 1'b0;
        if8.x = '0; if8.y = '0; if8.c = 1'b0;

        vt[0] = '{x: 4'hF, y: 4'h0, c: 1'b1, s: 4'h0, co: 1'b1, g: 1'b0, p: 1'b1};
        vt[1] = '{x: 4'h8, y: 4'h8, c: 1'b0, s: 4'h0, co: 1'b1, g: 1'b1, p: 1'b0};
        vt[2] = '{x: 4'h3, y: 4'h5, c: 1'b0, s: 4'h8, co: 1'b0, g: 1'b0, p: 1'b0};
        vt[3] = '{x: 4'hF, y: 4'h1, c: 1'b0, s: 4'h0, co: 1'b1, g: 1'b1, p: 1'b1};
        vt[4] = '{x: 4'hF, y: 4'hF, c: 1'b1, s: 4'hF, co: 1'b1, g: 1'b1, p: 1'b1};
        vt[5] = '{x: 4'h0, y: 4'h0, c: 1'b1, s: 4'h1, co: 1'b0, g: 1'b0, p: 1'b0};
        vt[6] = '{x: 4'hA, y: 4'h5, c: 1'b1, s: 4'h0, co: 1'b1, g: 1'b0, p: 1'b1};
        vt[7] = '{x: 4'h7, y: 4'h1, c: 1'b0, s: 4'h8, co: 1'b0, g: 1'b0, p: 1'b0};

        // WIDTH=1 exhaustive over {c,y,x}
        for (int v = 0; v < 8; v++) begin
            ex = v[0]; ey = v[1]; ec = v[2];
            if1.x = ex; if1.y = ey; if1.c = ec;
            #20;
            chk($sformatf("w1_s_%0d", v),  32'(if1.s),  32'(ex ^ ey ^ ec));
            chk($sformatf("w1_g_%0d", v),  32'(if1.g),  32'(ex & ey));
            chk($sformatf("w1_p_%0d", v),  32'(if1.p),  32'(ex | ey));
            chk($sformatf("w1_co_%0d", v), 32'(if1.co), 32'((ex & ey) | ((ex | ey) & ec)));
            chk($sformatf("w1_gpc_%0d", v), 32'(if1.g | (if1.p & ec)), 32'((ex & ey) | ((ex | ey) & ec)));
        end

        // WIDTH=1 spot checks
        if1.x = 1'b1; if1.y = 1'b1; if1.c = 1'b0; #20;
        chk("w1_spot1", 32'({if1.s, if1.g, if1.p, if1.co}), 32'(4'b0111));
        if1.x = 1'b1; if1.y = 1'b0; if1.c = 1'b1; #20;
        chk("w1_spot2", 32'({if1.s, if1.g, if1.p, if1.co}), 32'(4'b0011));

        // Combinational outputs with clk/rst undriven
        ifnc.x = 1'b1; ifnc.y = 1'b0; ifnc.c = 1'b0; #20;
        chk("nc_s", 32'(ifnc.s), 32'(1));
        chk("nc_g", 32'(ifnc.g), 32'(0));
        chk("nc_p", 32'(ifnc.p), 32'(1));

        // WIDTH=4 directed vectors
        for (int i = 0; i < 8; i++) begin
            if4.x = vt[i].x; if4.y = vt[i].y; if4.c = vt[i].c;
            #2;
            chk($sformatf("w4_s_%0d", i),  32'(if4.s),  32'(vt[i].s));
            chk($sformatf("w4_co_%0d", i), 32'(if4.co), 32'(vt[i].co));
            chk($sformatf("w4_g_%0d", i),  32'(if4.g),  32'(vt[i].g));
            chk($sformatf("w4_p_%0d", i),  32'(if4.p),  32'(vt[i].p));
        end

        // Registered path: reset held for two edges
        @(negedge clk);
        rst = 1'b1;
        if4.x = 4'h9; if4.y = 4'h9; if4.c = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_s_q",  32'(if4.s_q),  32'(0));
        chk("rst_co_q", 32'(if4.co_q), 32'(0));

        @(negedge clk);
        rst = 1'b0;
        if4.x = 4'h3; if4.y = 4'h5; if4.c = 1'b0;
        @(posedge clk); #1;
        chk("reg1_s_q",  32'(if4.s_q),  32'(4'h8));
        chk("reg1_co_q", 32'(if4.co_q), 32'(0));

        @(negedge clk);
        if4.x = 4'hF; if4.y = 4'h1; if4.c = 1'b0;
        @(posedge clk); #1;
        chk("reg2_s_q",  32'(if4.s_q),  32'(4'h0));
        chk("reg2_co_q", 32'(if4.co_q), 32'(1));

        // Reset priority while co=1 stays combinationally visible
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rp_pre_s",  32'(if4.s),  32'(4'h0));
        chk("rp_pre_co", 32'(if4.co), 32'(1));
        @(posedge clk); #1;
        chk("rp_s_q",  32'(if4.s_q),  32'(0));
        chk("rp_co_q", 32'(if4.co_q), 32'(0));
        chk("rp_s",    32'(if4.s),    32'(4'h0));
        chk("rp_co",   32'(if4.co),   32'(1));
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=8 random against an arithmetic model; g equals carry-out with zero carry-in
        for (int n = 0; n < 1000; n++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            if8.x = rx; if8.y = ry; if8.c = rc;
            #1;
            full = 9'(rx) + 9'(ry) + 9'(rc);
            gen  = 9'(rx) + 9'(ry);
            ep   = &(rx | ry);
            if (if8.s !== full[7:0] || if8.co !== full[8] || if8.g !== gen[8] ||
                if8.p !== ep || if8.co !== (if8.g | (if8.p & rc))) begin
                chk($sformatf("w8_rand_%0d x=%0h y=%0h c=%0d", n, rx, ry, rc),
                    32'({if8.co, if8.g, if8.p, if8.s}),
                    32'({full[8], gen[8], ep, full[7:0]}));
            end else begin
                tests++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bs_cell.md
Name: bs_cell

Overview:
- Bit-slice adder cell for the ALU adder tree, built from WIDTH adder bits.
- Produces sum bits, carry-out, and group generate/propagate for a higher-level carry-lookahead unit.
- Sum, generate, propagate and carry-out are purely combinational.
- Also provides a one-cycle registered copy of sum and carry-out for pipelined datapaths.
- WIDTH=1 is the single-bit full-adder cell.

Parameters:
- WIDTH, 1, number of bits in the slice; must be >= 1.

Ports:
- clk  input  1  system clock; used only by the registered outputs.
- rst  input  1  synchronous, active-high reset.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- c  input  1  carry-in to bit 0.
- s  output  WIDTH  combinational sum.
- g  output  1  combinational group generate.
- p  output  1  combinational group propagate.
- co  output  1  combinational carry-out of the MSB.
- s_q  output  WIDTH  registered sum.
- co_q  output  1  registered carry-out.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst. Nothing is asynchronous.
- Per-bit terms, for bit i:
  - gi = x[i] & y[i]
  - pi = x[i] | y[i] (inclusive-OR propagate)
- Internal carries:
  - k0 = c
  - k(i+1) = gi | (pi & ki)
- Sum: s[i] = x[i] ^ y[i] ^ ki.
- Carry-out: co = k(WIDTH).
- Group generate: g = g(W-1) | p(W-1)&g(W-2) | … | p(W-1)&…&p1&g0.
- Group propagate: p = AND of all pi.
- Invariant: co == g | (p & c) for every input combination.
- WIDTH=1 gives:
  - s = x^y^c
  - g = x&y
  - p = x|y
  - co = x&y | (x|y)&c
- s, g, p and co are combinational:
  - No dependence on clk or rst.
  - Valid with clk idle or undriven.
  - Settle within one propagation delay of an input change.
- Registered outputs:
  - On each rising clk: s_q <= s, co_q <= co.
  - Latency is 1 cycle.
  - When rst=1 at a rising edge: s_q <= 0, co_q <= 0. Reset wins over data.
  - Reset has no effect on s, g, p or co.
  - s_q and co_q are 0 after reset until the first non-reset edge.
- No overflow flag: the result is always WIDTH bits plus co (unsigned wrap).
- X and Y all-ones with c=1: s all-ones, co=1, g=1, p=1.
- No handshake and no state machine.

Optional Feature:
- Macro: BS_CELL_RIPPLE_EN.
- When defined:
  - Internal carries ki are built as a serial ripple chain.
  - g and p are also computed serially.
  - This gives minimum area.
- When undefined (default):
  - Each ki is computed with a flattened lookahead expression from c, gj and pj (j < i).
  - This gives minimum depth.
- All outputs are bit-identical in both builds; only timing and area differ.

Test Plan:
- WIDTH=1, exhaustive: sweep {c,y,x} from 000 to 111, wait 20 ns each.
  - Required: s == x^y^c.
  - Required: g|p&c == x&y | (x|y)&c for all 8 cases.
  - Spot checks: x=1,y=1,c=0 -> s=0,g=1,p=1,co=1; x=1,y=0,c=1 -> s=0,g=0,p=1,co=1.
- WIDTH=1 with clk undriven and rst undriven:
  - Required: s, g and p are correct for x=1,y=0,c=0 -> s=1,g=0,p=1.
- WIDTH=4, x=4'hF, y=4'h0, c=1:
  - Required: s=4'h0, co=1, g=0, p=1.
  - Then x=4'h8, y=4'h8, c=0 -> s=4'h0, co=1, g=1.
- WIDTH=4, registered path:
  - Hold rst=1 for 2 edges -> s_q=0, co_q=0.
  - Release rst, apply x=4'h3, y=4'h5, c=0 -> s_q=4'h8, co_q=0 one edge later.
- Reset priority: with x=4'hF, y=4'h1 (co=1), assert rst for one edge.
  - Required: s_q=0 and co_q=0 after that edge.
  - Required: s=4'h0 and co=1 remain combinationally valid throughout.
- Build with and without BS_CELL_RIPPLE_EN, WIDTH=8, 1000 random x,y,c:
  - Required: identical s, g, p and co, and co == g|(p&c) on every vector.
